// File: rtl/bvudiv_seq_ctrl_if.sv
// Handshake and operand/result bundle for the sequential unsigned divider.
// master drives the request side (start, a, b, c); slave is the divider.
interface bvudiv_seq_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             eq;

  modport master (
    output start, a, b, c,
    input  ready, done, q, r, eq
  );

  modport slave (
    input  start, a, b, c,
    output ready, done, q, r, eq
  );
endinterface

// File: rtl/bvudiv_seq_ctrl.sv
// Sequential restoring divider: computes bvudiv/bvurem of a by b one bit per
// cycle, MSB first, and flags whether the candidate quotient c was correct.
// Divide-by-zero yields q = all ones, r = a with no special handling.
//
// state | meaning
// IDLE  | ready for a request; results of the last operation held on q/r/eq
// DIV   | one restoring step per cycle, WIDTH cycles total
// DONE  | publish q/r/eq and pulse done on the way back to IDLE
module bvudiv_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  bvudiv_seq_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd_r;   // dividend, shifted left as bits are consumed
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] cand_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH:0]   rem_r;   // one spare bit so the shift-in never overflows

  logic             ready_r;
  logic             done_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic             eq_r;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_nx;
  logic             quo_bit;

  assign bus.ready = ready_r;
  assign bus.done  = done_r;
  assign bus.q     = q_r;
  assign bus.r     = r_r;
  assign bus.eq    = eq_r;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh  = (rem_r << 1) | {{WIDTH{1'b0}}, dvd_r[WIDTH-1]};
    quo_bit = (rem_sh >= {1'b0, dvs_r});
    rem_nx  = quo_bit ? (rem_sh - {1'b0, dvs_r}) : rem_sh;
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      dvd_r   <= '0;
      dvs_r   <= '0;
      cand_r  <= '0;
      quo_r   <= '0;
      rem_r   <= '0;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
      q_r     <= '0;
      r_r     <= '0;
      eq_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvd_r   <= bus.a;
            dvs_r   <= bus.b;
            cand_r  <= bus.c;
            quo_r   <= '0;
            rem_r   <= '0;
            cnt     <= '0;
            ready_r <= 1'b0;
            state   <= DIV;
          end
        end
        DIV: begin
          dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
          rem_r <= rem_nx;
          quo_r <= {quo_r[WIDTH-2:0], quo_bit};
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          q_r     <= quo_r;
          r_r     <= rem_r[WIDTH-1:0];
          eq_r    <= (cand_r == quo_r);
          done_r  <= 1'b1;
          ready_r <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ready_r <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bvudiv_seq_ctrl.sv
// Directed and sweep bench for bvudiv_seq_ctrl with a result scoreboard.
module tb_bvudiv_seq_ctrl;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bvudiv_seq_ctrl_if #(.WIDTH(W)) bus ();

  bvudiv_seq_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         eq;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference SMT-LIB bvudiv/bvurem, including divide-by-zero.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] c);
    exp_t e;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    e.eq = (c == e.q);
    return e;
  endfunction

  // Issue one request at the current negedge and follow it cycle by cycle
  // until its done pulse; optionally hammer start/a/b/c while busy.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input bit noise, input string tag);
    exp_t         e;
    logic [W-1:0] q_prev;
    logic [W-1:0] r_prev;
    logic         eq_prev;
    q_prev  = bus.q;
    r_prev  = bus.r;
    eq_prev = bus.eq;
    chk({tag, " ready at issue"}, 32'(bus.ready), 32'd1);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.c     = c;
    sb.push_back(model(a, b, c));
    for (int i = 0; i <= W + 1; i++) begin
      @(negedge clk);
      if (i <= W) begin
        chk({tag, " done low while busy"}, 32'(bus.done), 32'd0);
        chk({tag, " ready low while busy"}, 32'(bus.ready), 32'd0);
        chk({tag, " q held while busy"}, 32'(bus.q), 32'(q_prev));
        chk({tag, " r held while busy"}, 32'(bus.r), 32'(r_prev));
        chk({tag, " eq held while busy"}, 32'(bus.eq), 32'(eq_prev));
        if (noise) begin
          bus.start = 1'b1;
          bus.a     = (i == 0) ? W'(2) : W'($urandom);
          bus.b     = (i == 0) ? W'(2) : W'($urandom);
          bus.c     = W'($urandom);
        end else begin
          bus.start = 1'b0;
        end
      end else begin
        chk({tag, " done pulse"}, 32'(bus.done), 32'd1);
        chk({tag, " ready after done"}, 32'(bus.ready), 32'd1);
        e = sb.pop_front();
        chk({tag, " q"}, 32'(bus.q), 32'(e.q));
        chk({tag, " r"}, 32'(bus.r), 32'(e.r));
        chk({tag, " eq"}, 32'(bus.eq), 32'(e.eq));
        bus.start = 1'b0;
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.c     = '0;
    repeat (3) @(negedge clk);
    chk("reset ready", 32'(bus.ready), 32'd1);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset q", 32'(bus.q), 32'd0);
    chk("reset r", 32'(bus.r), 32'd0);
    chk("reset eq", 32'(bus.eq), 32'd0);

    // Start in the very first cycle with reset released.
    rst = 1'b0;
    do_op(4'd13, 4'd3, 4'd4, 1'b0, "basic");
    do_op(4'd9, 4'd0, 4'd15, 1'b0, "div0");
    do_op(4'd0, 4'd7, 4'd1, 1'b0, "zero dividend");
    do_op(4'd15, 4'd1, 4'd15, 1'b0, "divide by one");
    do_op(4'd13, 4'd3, 4'd4, 1'b1, "busy protect");

    // Reset two cycles into an operation; it must never complete.
    bus.start = 1'b1;
    bus.a     = 4'd14;
    bus.b     = 4'd5;
    bus.c     = 4'd2;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      chk("abort done", 32'(bus.done), 32'd0);
      chk("abort ready", 32'(bus.ready), 32'd1);
      chk("abort q", 32'(bus.q), 32'd0);
      chk("abort r", 32'(bus.r), 32'd0);
      chk("abort eq", 32'(bus.eq), 32'd0);
    end
    rst = 1'b0;
    do_op(4'd14, 4'd5, 4'd2, 1'b0, "after abort");

    // All operand pairs, issued back to back with the correct candidate.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [W-1:0] c;
        c = (b == 0) ? 4'hF : W'(a / b);
        do_op(W'(a), W'(b), c, ((a + b) % 3) == 0,
              $sformatf("sweep a=%0d b=%0d", a, b));
      end
    end

    @(negedge clk);
    chk("idle done low", 32'(bus.done), 32'd0);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
